debounced_logic_gate: RTL and testbench
=======================================

Name: debounced_logic_gate

Overview:
Parametrised, registered N-input logic gate for the Tang Primer board. Each raw input (button or switch) is synchronised and debounced. A runtime-selectable logic operation then reduces the clean inputs to one registered output. It supersedes the fixed 2-input combinational OR and drives LEDs or downstream logic directly from board I/O.

Parameters:
N_IN, 2, number of input channels (2..8)
DEB_CYCLES, 240000, consecutive stable cycles required to accept a new input level (10 ms at 24 MHz); must be >= 1
CNT_W, $clog2(DEB_CYCLES+1), debounce counter width (derived, not overridden)

Ports:
clk  input  1  system clock; all flops on rising edge
rst_n  input  1  asynchronous active-low reset
in_raw  input  N_IN  raw asynchronous inputs
op  input  3  operation select; synchronous to clk
in_clean  output  N_IN  debounced input levels
out0  output  1  registered gate result
out_changed  output  1  one-cycle pulse when out0 changes value

Behaviour:
- Reset (async assert, sync release): sync flops, in_clean, all counters, out0 and out_changed clear to 0.
- Synchroniser: per channel, 2-flop chain; sync_q2 is in_raw delayed by 2 edges.
- Debounce, per channel, checked each edge:
  - sync_q2 == in_clean: cnt <= 0.
  - sync_q2 != in_clean and cnt == DEB_CYCLES-1: in_clean <= sync_q2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- Glitch rejection: a return to the in_clean level before acceptance clears cnt. A pulse shorter than DEB_CYCLES cycles at sync_q2 never reaches in_clean.
- Counter never exceeds DEB_CYCLES-1; no wrap.
- Channels are fully independent. Simultaneous changes on several channels are each debounced separately.
- op encoding: 0 OR, 1 AND, 2 XOR, 3 NOR, 4 NAND, 5 XNOR; 6 and 7 reserved, behave as OR.
- Reduction is over all N_IN bits of in_clean.
- out0 <= f(op, in_clean) every edge; no enable.
- out_changed <= (new out0 != current out0), registered alongside out0, high exactly one cycle per change.
- Latency from raw input: out0 reflects a clean-stable raw change on rising edge DEB_CYCLES+3. Edge 1 is the first edge sampling the new raw level (2 sync + DEB_CYCLES debounce + 1 output).
- Latency from op change: out0 updates 1 edge later.
- op and input changes on the same edge: out0 uses the new op with the in_clean value present at that edge.
- After reset release with in_clean == 0, out0 goes to f(op, 0) on the first edge. For op 3/4/5 this gives out0=1 and one out_changed pulse.
- Reset mid-count discards partial progress; in_clean returns to 0 regardless of in_raw.

Decomposition:
- Shared package logic_gate_pkg: op encoding constants (OP_OR..OP_XNOR, OP_W=3) and a pure function gate_reduce(op, vec).
- Sub-module input_debouncer: one channel holding sync chain, counter and clean flop; parameter DEB_CYCLES; ports clk, rst_n, raw, clean. Instantiated N_IN times via generate.
- Top level holds only the reduction register and out_changed logic.

Test Plan (N_IN=2, DEB_CYCLES=4):
1. Reset sweep, op=0: in_raw 00→01→10→11, each held 20 cycles → out0 0,1,1,1. Each out0 update lands exactly 7 edges after the raw change (DEB_CYCLES+3).
2. op=2 (XOR), in_raw=11 stable, then op=1 (AND) → out0 goes 0→1 one edge after the op change; out_changed high for exactly 1 cycle.
3. Glitch: in_raw ch0 0→1 for 3 cycles then back to 0 → in_clean stays 00, out0 stays 0, out_changed never asserts. Same pulse held 4 cycles → in_clean[0] rises.
4. NOR after reset: op=3, in_raw=00, release rst_n → out0=1 on the first edge with one out_changed pulse. in_raw=10 held → out0=0 after 7 edges.
5. Async reset mid-count: in_raw=11, op=1, assert rst_n low while cnt=2, not aligned to clk → in_clean, out0 and out_changed go 0 immediately. After release, out0=1 at edge DEB_CYCLES+3.
6. Reserved op=6/7 with in_raw=01 → out0=1 (OR behaviour). Op 4 (NAND) with in_raw=11 → out0=0.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// Shared definitions for the debounced logic gate: operation encoding and
// the reduction function that turns a vector of clean inputs into one bit.
// Pure combinational helpers only; no ports.
package logic_gate_pkg;

  localparam int OP_W   = 3;
  // Widest input vector the reduction function accepts.
  localparam int MAX_IN = 8;

  localparam logic [OP_W-1:0] OP_OR   = 3'd0;
  localparam logic [OP_W-1:0] OP_AND  = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

  // Reduce the low n bits of vec with the selected operation. Bits at and
  // above n are ignored so that a zero-padded vector works for AND/NAND too.
  // Codes 6 and 7 are reserved and fall back to OR.
  function automatic logic gate_reduce(input logic [OP_W-1:0]   op,
                                       input logic [MAX_IN-1:0] vec,
                                       input int                n);
    logic r_or;
    logic r_and;
    logic r_xor;
    logic res;
    r_or  = 1'b0;
    r_and = 1'b1;
    r_xor = 1'b0;
    for (int i = 0; i < MAX_IN; i++) begin
      if (i < n) begin
        r_or  = r_or | vec[i];
        r_and = r_and & vec[i];
        r_xor = r_xor ^ vec[i];
      end
    end
    case (op)
      OP_AND:  res = r_and;
      OP_XOR:  res = r_xor;
      OP_NOR:  res = ~r_or;
      OP_NAND: res = ~r_and;
      OP_XNOR: res = ~r_xor;
      default: res = r_or;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// One input channel: 2-flop synchroniser, stability counter, clean level flop.
// Latency: a stable raw change reaches clean on edge DEB_CYCLES+2; no backpressure.
// Ports: clk, rst_n (async active-low), raw (async input), clean (debounced level).
module input_debouncer #(
  parameter int DEB_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean
);

  localparam int              CNT_W   = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             clean_q;
  logic             clean_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter measures how many consecutive edges the synchronised level
  // has disagreed with clean. Any agreement restarts it, which is what
  // rejects glitches shorter than DEB_CYCLES. It saturates at CNT_MAX by
  // construction since reaching it always accepts and clears.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = cnt_q;
    if (sync_q2 == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      clean_d = sync_q2;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/debounced_logic_gate.sv
// Registered N-input logic gate fed by per-channel debouncers (board buttons/switches).
// Latency: raw change -> out0 on edge DEB_CYCLES+3; op change -> out0 next edge; no backpressure.
// Ports: clk, rst_n, in_raw[N_IN], op[3] -> in_clean[N_IN], out0, out_changed (1-cycle pulse).
module debounced_logic_gate
  import logic_gate_pkg::*;
#(
  parameter int N_IN       = 2,       // 2..8
  parameter int DEB_CYCLES = 240000   // >= 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in_raw,
  input  logic [OP_W-1:0] op,
  output logic [N_IN-1:0] in_clean,
  output logic            out0,
  output logic            out_changed
);

  logic [MAX_IN-1:0] vec_pad;
  logic              out0_d;
  logic              out0_q;
  logic              out_changed_q;

  for (genvar g = 0; g < N_IN; g++) begin : g_ch
    input_debouncer #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (in_raw[g]),
      .clean(in_clean[g])
    );
  end

  // Zero-pad to the function's fixed width; the function masks off the pad.
  always_comb begin
    vec_pad           = '0;
    vec_pad[N_IN-1:0] = in_clean;
  end

  assign out0_d = gate_reduce(op, vec_pad, N_IN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_q        <= 1'b0;
      out_changed_q <= 1'b0;
    end else begin
      out0_q        <= out0_d;
      out_changed_q <= (out0_d != out0_q);
    end
  end

  assign out0        = out0_q;
  assign out_changed = out_changed_q;

endmodule

// File: tb/tb_debounced_logic_gate.sv
module tb_debounced_logic_gate;

  localparam int N_IN = 2;
  localparam int DEB  = 4;

  logic            clk    = 1'b0;
  logic            rst_n  = 1'b0;
  logic [N_IN-1:0] in_raw = '0;
  logic [2:0]      op     = 3'd0;
  logic [N_IN-1:0] in_clean;
  logic            out0;
  logic            out_changed;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  debounced_logic_gate #(
    .N_IN      (N_IN),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_raw     (in_raw),
    .op         (op),
    .in_clean   (in_clean),
    .out0       (out0),
    .out_changed(out_changed)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Gate function written with reduction operators.
  function automatic logic model_f(input logic [2:0] o, input logic [N_IN-1:0] v);
    case (o)
      3'd1:    return &v;
      3'd2:    return ^v;
      3'd3:    return ~|v;
      3'd4:    return ~&v;
      3'd5:    return ~^v;
      default: return |v;
    endcase
  endfunction

  // hist holds the raw value sampled at each edge since reset (zeros stand in
  // for the reset period). A channel's clean level flips when the last DEB
  // values presented after the 2-edge synchroniser all disagree with it.
  logic [N_IN-1:0] m_clean = '0;
  logic            m_out   = 1'b0;
  logic            m_chg   = 1'b0;
  logic [N_IN-1:0] hist[$];

  always @(posedge clk or negedge rst_n) begin
    logic [N_IN-1:0] nc;
    logic            no;
    logic            all_diff;
    if (!rst_n) begin
      m_clean = '0;
      m_out   = 1'b0;
      m_chg   = 1'b0;
      hist.delete();
      for (int i = 0; i < DEB + 2; i++) hist.push_back('0);
    end else begin
      no = model_f(op, m_clean);
      nc = m_clean;
      for (int ch = 0; ch < N_IN; ch++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++)
          if (hist[hist.size() - 2 - j][ch] == m_clean[ch]) all_diff = 1'b0;
        if (all_diff) nc[ch] = ~m_clean[ch];
      end
      m_chg   = (no != m_out);
      m_out   = no;
      m_clean = nc;
      hist.push_back(in_raw);
      while (hist.size() > DEB + 2) void'(hist.pop_front());
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_in_clean", 8'(in_clean), 8'(m_clean));
    check("cmp_out0", 8'(out0), 8'(m_out));
    check("cmp_out_changed", 8'(out_changed), 8'(m_chg));
  end

  task automatic at_edge(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  logic [N_IN-1:0] pats    [3] = '{2'b01, 2'b10, 2'b11};
  logic [N_IN-1:0] prev_cl [3] = '{2'b00, 2'b01, 2'b10};
  logic            prev_out[3] = '{1'b0, 1'b1, 1'b1};
  logic            new_out [3] = '{1'b1, 1'b1, 1'b1};
  logic            seen_chg;
  logic [N_IN-1:0] seen_clean;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_clean", 8'(in_clean), 8'h0);
    check("rst_out0", 8'(out0), 8'h0);
    check("rst_out_changed", 8'(out_changed), 8'h0);
    rst_n = 1'b1;

    // 1. OR sweep with exact latency
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_raw = pats[k];
      at_edge(DEB + 1);
      check("t1_clean_before", 8'(in_clean), 8'(prev_cl[k]));
      at_edge(1);
      check("t1_clean_after", 8'(in_clean), 8'(pats[k]));
      check("t1_out_before", 8'(out0), 8'(prev_out[k]));
      at_edge(1);
      check("t1_out_after", 8'(out0), 8'(new_out[k]));
      if (k == 0) check("t1_chg_pulse", 8'(out_changed), 8'h1);
      repeat (13) @(negedge clk);
    end

    // 2. XOR then AND with inputs 11
    @(negedge clk);
    op = 3'd2;
    at_edge(1);
    check("t2_xor_out", 8'(out0), 8'h0);
    check("t2_xor_chg", 8'(out_changed), 8'h1);
    at_edge(1);
    check("t2_xor_chg_end", 8'(out_changed), 8'h0);
    @(negedge clk);
    op = 3'd1;
    at_edge(1);
    check("t2_and_out", 8'(out0), 8'h1);
    check("t2_and_chg", 8'(out_changed), 8'h1);
    at_edge(1);
    check("t2_and_chg_end", 8'(out_changed), 8'h0);

    // 3. Glitch rejection: 3-cycle pulse dropped, 4-cycle pulse accepted
    @(negedge clk);
    op     = 3'd0;
    in_raw = 2'b00;
    repeat (20) @(negedge clk);
    check("t3_idle_out", 8'(out0), 8'h0);
    in_raw = 2'b01;
    repeat (3) @(negedge clk);
    in_raw     = 2'b00;
    seen_chg   = 1'b0;
    seen_clean = '0;
    repeat (15) begin
      @(negedge clk);
      seen_chg   = seen_chg | out_changed;
      seen_clean = seen_clean | in_clean;
    end
    check("t3_glitch_clean", 8'(seen_clean), 8'h0);
    check("t3_glitch_chg", 8'(seen_chg), 8'h0);
    in_raw = 2'b01;
    repeat (4) @(negedge clk);
    in_raw     = 2'b00;
    seen_clean = '0;
    repeat (15) begin
      @(negedge clk);
      seen_clean = seen_clean | in_clean;
    end
    check("t3_pulse4_clean", 8'(seen_clean), 8'h1);

    // 4. NOR straight out of reset
    @(negedge clk);
    rst_n  = 1'b0;
    op     = 3'd3;
    in_raw = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    at_edge(1);
    check("t4_nor_out", 8'(out0), 8'h1);
    check("t4_nor_chg", 8'(out_changed), 8'h1);
    at_edge(1);
    check("t4_nor_chg_end", 8'(out_changed), 8'h0);
    @(negedge clk);
    in_raw = 2'b10;
    at_edge(DEB + 2);
    check("t4_nor_hold", 8'(out0), 8'h1);
    at_edge(1);
    check("t4_nor_drop", 8'(out0), 8'h0);

    // 5. Asynchronous reset part-way through a count
    @(negedge clk);
    in_raw = 2'b11;
    op     = 3'd1;
    at_edge(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_arst_clean", 8'(in_clean), 8'h0);
    check("t5_arst_out", 8'(out0), 8'h0);
    check("t5_arst_chg", 8'(out_changed), 8'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    at_edge(DEB + 2);
    check("t5_out_hold", 8'(out0), 8'h0);
    at_edge(1);
    check("t5_out_rise", 8'(out0), 8'h1);
    check("t5_clean", 8'(in_clean), 8'h3);

    // 6. Reserved codes act as OR; NAND of 11
    @(negedge clk);
    op     = 3'd6;
    in_raw = 2'b01;
    repeat (12) @(negedge clk);
    check("t6_op6_clean", 8'(in_clean), 8'h1);
    check("t6_op6_out", 8'(out0), 8'h1);
    op = 3'd7;
    at_edge(1);
    check("t6_op7_out", 8'(out0), 8'h1);
    @(negedge clk);
    op     = 3'd4;
    in_raw = 2'b11;
    repeat (12) @(negedge clk);
    check("t6_nand_out", 8'(out0), 8'h0);
    check("t6_nand_clean", 8'(in_clean), 8'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
